ram_burst_ctrl: RTL
===================

RAM_BURST_CTRL -- requirements
Module: ram_burst_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, RAM address width.
REQ-002 SHALL have parameter DATA_W, default 8, RAM data width.
REQ-003 SHALL have parameter RD_LAT, default 1, cycles from ram_addr presented to ram_dout valid (range 0..3).
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_write in 1 (1=write, 0=read), cmd_addr in ADDR_W (start address), cmd_len in ADDR_W (beats minus 1).
REQ-007 SHALL have ports wr_data in DATA_W, wr_valid in 1, wr_ready out 1: write-data stream.
REQ-008 SHALL have ports rd_data out DATA_W, rd_valid out 1: read-data stream, no backpressure.
REQ-009 SHALL have port done  output  1  one-cycle pulse at burst end.
REQ-010 SHALL have ports ram_we out 1, ram_addr out ADDR_W, ram_din out DATA_W, ram_dout in DATA_W: RAM initiator port.
REQ-011 SHALL have port chk  output  DATA_W  burst checksum (see Configuration).

Function
REQ-012 SHALL implement FSM states IDLE, WRITE, READ, DRAIN, DONE.
REQ-013 SHALL assert cmd_ready only in IDLE; command is accepted on cmd_valid & cmd_ready and is latched.
REQ-014 SHALL transfer exactly cmd_len+1 beats (1..2^ADDR_W).
REQ-015 SHALL increment the address by 1 per beat modulo 2^ADDR_W (15 wraps to 0 at defaults).
REQ-016 WRITE: SHALL assert wr_ready while beats remain; each wr_valid & wr_ready beat SHALL drive registered ram_we=1, ram_addr, and ram_din on the next cycle.
REQ-017 WRITE: a cycle without a handshake SHALL produce ram_we=0 on the next cycle; no beat is duplicated or dropped.
REQ-018 READ: SHALL present one address per cycle on registered ram_addr with ram_we=0, then enter DRAIN until the last data returns.
REQ-019 SHALL capture ram_dout RD_LAT cycles after each address and present it on rd_data with rd_valid=1 for exactly one cycle, in address order, one beat per cycle.
REQ-020 DONE: SHALL pulse done for one cycle, either the cycle after the final ram_we or in the same cycle as the final rd_valid, then return to IDLE.
REQ-021 SHALL ignore wr_valid outside WRITE and SHALL not accept cmd_valid while busy.
REQ-022 ram_we SHALL never be 1 outside WRITE beats.

Reset
REQ-023 While rst_n=0 at a clock edge: state=IDLE, ram_we=0, ram_addr=0, ram_din=0, rd_valid=0, rd_data=0, done=0, chk=0, wr_ready=0.
REQ-024 After reset, cmd_ready SHALL be 1.
REQ-025 Reset mid-burst SHALL abort the burst: no further ram_we or rd_valid, and no done pulse.

Configuration
REQ-026 With macro RAM_BURST_CHECKSUM_EN defined, chk SHALL clear on command accept and add every transferred data byte modulo 2^DATA_W; it SHALL be valid and held from done until the next accept.
REQ-027 Without RAM_BURST_CHECKSUM_EN, chk SHALL be tied to 0 and no adder SHALL be synthesized.

Structure
REQ-028 Package ram_burst_pkg SHALL hold the FSM state enum typedef and the ADDR_W/DATA_W default constants.
REQ-029 Sub-module ram_rd_pipe SHALL implement the RD_LAT-deep valid shift register and data capture.

Verification
REQ-030 Reset: rst_n=0 for 2 cycles -> cmd_ready=1; ram_we, rd_valid, done, chk all 0.
REQ-031 Write: addr 1, len 2, data 10,20,30 back-to-back -> ram_we high 3 cycles at addr 1,2,3 with din 10,20,30; done once; chk=60 with macro.
REQ-032 Read: addr 1, len 2, RAM model RD_LAT=1 -> rd_data 10,20,30 on consecutive cycles; done in the same cycle as 30.
REQ-033 Wrap: write addr 14, len 3 -> addresses 14,15,0,1.
REQ-034 Stall: wr_valid low 2 cycles after beat 1 of 3 -> 2-cycle ram_we gap, exactly 3 writes.
REQ-035 Abort: rst_n=0 after 2 of 4 write beats -> ram_we=0 the following cycle, no done, cmd_ready=1 after reset.

Source files
------------

// File: rtl/ram_burst_pkg.sv
// Shared types and default widths for the RAM burst controller.
package ram_burst_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  // Controller FSM states
  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/ram_burst_ctrl_if.sv
// Bus bundle for ram_burst_ctrl: command, write stream, read stream,
// completion/checksum and the RAM initiator port.
// The slave modport is the controller's view; master is the requester/RAM side.
interface ram_burst_ctrl_if
  import ram_burst_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] cmd_len;

  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;

  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  logic              done;
  logic [DATA_W-1:0] chk;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  wr_data, wr_valid,
    input  ram_dout,
    output cmd_ready, wr_ready,
    output rd_data, rd_valid,
    output done, chk,
    output ram_we, ram_addr, ram_din
  );

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output wr_data, wr_valid,
    output ram_dout,
    input  cmd_ready, wr_ready,
    input  rd_data, rd_valid,
    input  done, chk,
    input  ram_we, ram_addr, ram_din
  );

endinterface

// File: rtl/ram_rd_pipe.sv
// Read-return pipeline: delays the address-issue valid by RD_LAT cycles so it
// lines up with ram_dout, then captures the data into rd_data/rd_valid.
// tap/tap_last show the beat whose data is on ram_dout this cycle.
module ram_rd_pipe #(
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vld_p0,
  input  logic              last_p0,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              tap,
  output logic              tap_last,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  // At least one register so RD_LAT=0 still elaborates
  localparam int SR_W = (RD_LAT > 0) ? RD_LAT : 1;

  logic [SR_W-1:0] vld_sr;
  logic [SR_W-1:0] last_sr;
  logic [SR_W:0]   vld_p;
  logic [SR_W:0]   last_p;

  assign vld_p    = {vld_sr, vld_p0};
  assign last_p   = {last_sr, last_p0};
  assign tap      = vld_p[RD_LAT];
  assign tap_last = last_p[RD_LAT];

  // Valid shift register; cleared on reset so an aborted read emits nothing
  always_ff @(posedge clk) begin
    if (!rst_n) vld_sr <= '0;
    else        vld_sr <= vld_p[SR_W-1:0];
  end

  // Last-beat marker rides alongside valid; only meaningful when valid is set
  always_ff @(posedge clk) begin
    last_sr <= last_p[SR_W-1:0];
  end

  // Capture returned data for exactly one cycle per beat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= tap;
      if (tap) rd_data <= ram_dout;
    end
  end

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst controller translating write/read burst commands into single-beat
// RAM accesses with wrapping addresses. Optional burst checksum is enabled
// by defining RAM_BURST_CHECKSUM_EN; otherwise chk is tied to zero.
module ram_burst_ctrl
  import ram_burst_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1
) (
  input logic             clk,
  input logic             rst_n,
  ram_burst_ctrl_if.slave bus
);

  state_t            state, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              is_wr, is_wr_d;

  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;

  logic              vld_p0, vld_p0_d;
  logic              last_p0, last_p0_d;
  logic              tap, tap_last;

  logic              accept;
  logic              wr_beat;

  assign accept  = (state == IDLE) && bus.cmd_valid;
  assign wr_beat = (state == WRITE) && bus.wr_valid;

  assign bus.ram_we   = ram_we_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_din  = ram_din_q;

  // Next-state, handshake outputs and next values of registered RAM signals
  always_comb begin
    state_d       = state;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    is_wr_d       = is_wr;
    ram_we_d      = 1'b0;
    ram_addr_d    = ram_addr_q;
    ram_din_d     = ram_din_q;
    vld_p0_d      = 1'b0;
    last_p0_d     = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.wr_ready  = 1'b0;
    bus.done      = 1'b0;
    case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          is_wr_d = bus.cmd_write;
          addr_d  = bus.cmd_addr;
          cnt_d   = bus.cmd_len;
          state_d = bus.cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        bus.wr_ready = 1'b1;
        if (bus.wr_valid) begin
          ram_we_d   = 1'b1;
          ram_addr_d = addr_q;
          ram_din_d  = bus.wr_data;
          addr_d     = addr_q + ADDR_W'(1);
          cnt_d      = cnt_q - ADDR_W'(1);
          // Final beat: DRAIN covers the cycle its ram_we is on the bus
          if (cnt_q == '0) state_d = DRAIN;
        end
      end
      READ: begin
        ram_addr_d = addr_q;
        vld_p0_d   = 1'b1;
        last_p0_d  = (cnt_q == '0);
        addr_d     = addr_q + ADDR_W'(1);
        cnt_d      = cnt_q - ADDR_W'(1);
        if (cnt_q == '0) state_d = DRAIN;
      end
      DRAIN: begin
        // Reads leave when the last beat's data is on ram_dout, so DONE
        // coincides with its rd_valid
        if (is_wr || (tap && tap_last)) state_d = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered RAM/control outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      vld_p0     <= 1'b0;
      last_p0    <= 1'b0;
    end else begin
      state      <= state_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      vld_p0     <= vld_p0_d;
      last_p0    <= last_p0_d;
    end
  end

  // Burst bookkeeping, always loaded on accept before use
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    cnt_q  <= cnt_d;
    is_wr  <= is_wr_d;
  end

  // ---- read return pipeline boundary ----
  ram_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .vld_p0   (vld_p0),
    .last_p0  (last_p0),
    .ram_dout (bus.ram_dout),
    .tap      (tap),
    .tap_last (tap_last),
    .rd_data  (bus.rd_data),
    .rd_valid (bus.rd_valid)
  );

`ifdef RAM_BURST_CHECKSUM_EN
  logic [DATA_W-1:0] chk_q, chk_d;

  function automatic logic [DATA_W-1:0] chk_add(input logic [DATA_W-1:0] acc,
                                                input logic [DATA_W-1:0] val);
    return acc + val;
  endfunction

  // Checksum accumulates read data as it is captured so it is final with done
  always_comb begin
    chk_d = chk_q;
    if (accept)       chk_d = '0;
    else if (wr_beat) chk_d = chk_add(chk_q, bus.wr_data);
    else if (tap)     chk_d = chk_add(chk_q, bus.ram_dout);
  end

  // Checksum register
  always_ff @(posedge clk) begin
    if (!rst_n) chk_q <= '0;
    else        chk_q <= chk_d;
  end

  assign bus.chk = chk_q;
`else
  assign bus.chk = '0;
`endif

endmodule
